// File: rtl/shift_pkg.sv
// Shared types and helpers for the RV64 shift execute stage.
// Opcode encoding, operand widths, bit reversal and opcode classification.
package shift_pkg;

  localparam int XLEN    = 64;
  localparam int SHAMT_W = 6;

  typedef enum logic [2:0] {
    SLL  = 3'd0,
    SRL  = 3'd1,
    SRA  = 3'd2,
    SLLW = 3'd3,
    SRLW = 3'd4,
    SRAW = 3'd5
  } shift_op_t;

  function automatic logic [XLEN-1:0] bitrev64(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) begin
      r[i] = v[XLEN-1-i];
    end
    return r;
  endfunction

  function automatic logic is_word_op(input shift_op_t op);
    return (op == SLLW) || (op == SRLW) || (op == SRAW);
  endfunction

  // Encodings 6 and 7 are unassigned and reported as illegal.
  function automatic logic is_legal_op(input logic [2:0] op);
    return op <= 3'd5;
  endfunction

endpackage

// File: rtl/shiftright.sv
// Logical-right barrel shifter: one conditional power-of-two stage per shamt bit.
module shiftright #(
  parameter int WIDTH   = 64,
  parameter int SHAMT_W = 6
) (
  input  logic [WIDTH-1:0]   data,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   result
);

  logic [WIDTH-1:0] stage [SHAMT_W+1];

  assign stage[0] = data;

  for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_stage
    assign stage[gi+1] = shamt[gi] ? (stage[gi] >> (1 << gi)) : stage[gi];
  end

  assign result = stage[SHAMT_W];

endmodule

// File: rtl/shift_exec_stage.sv
// Two-stage pipelined RV64 shift execute unit (SLL/SRL/SRA and W forms).
// Every shift is mapped onto one logical-right shifter plus a fill mask.
module shift_exec_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int RD_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [RD_W-1:0]  in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [RD_W-1:0]  out_rd,
  output logic             out_err,
  output logic             busy
);

  // Stage 1 state
  logic               s1_valid_q,   s1_valid_d;
  shift_op_t          s1_op_q,      s1_op_d;
  logic [SHAMT_W-1:0] s1_shamt_q,   s1_shamt_d;
  logic [WIDTH-1:0]   s1_operand_q, s1_operand_d;
  logic               s1_sign_q,    s1_sign_d;
  logic [RD_W-1:0]    s1_rd_q,      s1_rd_d;
  logic               s1_err_q,     s1_err_d;

  // Stage 2 state (drives the outputs directly)
  logic               s2_valid_q,   s2_valid_d;
  logic [WIDTH-1:0]   out_result_q, out_result_d;
  logic [RD_W-1:0]    out_rd_q,     out_rd_d;
  logic               out_err_q,    out_err_d;

  logic adv2;
  logic accept;

  shift_op_t          dec_op;
  logic [SHAMT_W-1:0] dec_shamt;
  logic [WIDTH-1:0]   dec_operand;
  logic               dec_sign;
  logic               dec_err;

  logic [WIDTH-1:0]   lsr;
  logic [WIDTH-1:0]   mask;
  logic [WIDTH-1:0]   raw;
  logic [WIDTH-1:0]   s2_result;

  logic               unused_b_hi;
  assign unused_b_hi = ^in_b[WIDTH-1:SHAMT_W];

  assign adv2     = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !rst && !flush && (!s1_valid_q || adv2);
  assign accept   = in_valid && in_ready;

  always_comb begin
    dec_op      = shift_op_t'(in_op);
    dec_err     = !is_legal_op(in_op);
    dec_shamt   = is_word_op(dec_op) ? {1'b0, in_b[4:0]} : in_b[SHAMT_W-1:0];
    dec_operand = in_a;
    case (dec_op)
      SLL, SLLW: dec_operand = bitrev64(in_a);
      SRLW:      dec_operand = {{(WIDTH-32){1'b0}}, in_a[31:0]};
      SRAW:      dec_operand = {{(WIDTH-32){in_a[31]}}, in_a[31:0]};
      default:   dec_operand = in_a;
    endcase
    dec_sign = ((dec_op == SRA) || (dec_op == SRAW)) ? dec_operand[WIDTH-1] : 1'b0;
  end

  shiftright #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_shift_data (
    .data   (s1_operand_q),
    .shamt  (s1_shamt_q),
    .result (lsr)
  );

  // The mask marks bit positions that came from the operand, so ~mask is the vacated fill.
  shiftright #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_shift_mask (
    .data   ({WIDTH{1'b1}}),
    .shamt  (s1_shamt_q),
    .result (mask)
  );

  always_comb begin
    raw = '0;
    case (s1_op_q)
      SRL, SRLW: raw = lsr;
      SRA, SRAW: raw = lsr | (s1_sign_q ? ~mask : '0);
      SLL, SLLW: raw = bitrev64(lsr);
      default:   raw = '0;
    endcase
    s2_result = is_word_op(s1_op_q) ? {{(WIDTH-32){raw[31]}}, raw[31:0]} : raw;
    if (s1_err_q) begin
      s2_result = '0;
    end
  end

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_op_d      = s1_op_q;
    s1_shamt_d   = s1_shamt_q;
    s1_operand_d = s1_operand_q;
    s1_sign_d    = s1_sign_q;
    s1_rd_d      = s1_rd_q;
    s1_err_d     = s1_err_q;
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (accept) begin
      s1_valid_d   = 1'b1;
      s1_op_d      = dec_op;
      s1_shamt_d   = dec_shamt;
      s1_operand_d = dec_operand;
      s1_sign_d    = dec_sign;
      s1_rd_d      = in_rd;
      s1_err_d     = dec_err;
    end else if (adv2) begin
      s1_valid_d = 1'b0;
    end
  end

  // Outputs only change on a load, so they hold while writeback stalls.
  always_comb begin
    s2_valid_d   = s2_valid_q;
    out_result_d = out_result_q;
    out_rd_d     = out_rd_q;
    out_err_d    = out_err_q;
    if (flush) begin
      s2_valid_d = 1'b0;
    end else if (adv2) begin
      s2_valid_d   = 1'b1;
      out_result_d = s2_result;
      out_rd_d     = s1_rd_q;
      out_err_d    = s1_err_q;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_op_q      <= SLL;
      s1_shamt_q   <= '0;
      s1_operand_q <= '0;
      s1_sign_q    <= 1'b0;
      s1_rd_q      <= '0;
      s1_err_q     <= 1'b0;
      s2_valid_q   <= 1'b0;
      out_result_q <= '0;
      out_rd_q     <= '0;
      out_err_q    <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_op_q      <= s1_op_d;
      s1_shamt_q   <= s1_shamt_d;
      s1_operand_q <= s1_operand_d;
      s1_sign_q    <= s1_sign_d;
      s1_rd_q      <= s1_rd_d;
      s1_err_q     <= s1_err_d;
      s2_valid_q   <= s2_valid_d;
      out_result_q <= out_result_d;
      out_rd_q     <= out_rd_d;
      out_err_q    <= out_err_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = out_result_q;
  assign out_rd     = out_rd_q;
  assign out_err    = out_err_q;
  assign busy       = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Directed and randomized bench for shift_exec_stage against an arithmetic reference model.
module tb_shift_exec_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = 3'd0;
  logic [63:0] in_a = '0;
  logic [63:0] in_b = '0;
  logic [4:0]  in_rd = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_result;
  logic [4:0]  out_rd;
  logic        out_err;
  logic        busy;

  always #5 clk = ~clk;

  shift_exec_stage #(.WIDTH(64), .RD_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_rd      (in_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_err    (out_err),
    .busy       (busy)
  );

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          tests_run = 0;
  int          failures = 0;
  int          xfers = 0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_res = '0;
  logic [4:0]  prev_rd = '0;
  logic        last_acc = 1'b0;
  logic [63:0] last_res = '0;
  logic        last_err = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference semantics: plain shift operators, W forms on the low word then sign-extended.
  function automatic exp_t model(input logic [2:0] op, input logic [63:0] a,
                                 input logic [63:0] b, input logic [4:0] rd);
    exp_t        e;
    logic [31:0] w;
    e.rd  = rd;
    e.err = 1'b0;
    e.res = '0;
    w     = '0;
    case (op)
      3'd0: e.res = a << b[5:0];
      3'd1: e.res = a >> b[5:0];
      3'd2: e.res = $signed(a) >>> b[5:0];
      3'd3: w = a[31:0] << b[4:0];
      3'd4: w = a[31:0] >> b[4:0];
      3'd5: w = $signed(a[31:0]) >>> b[4:0];
      default: e.err = 1'b1;
    endcase
    if (op >= 3'd3 && op <= 3'd5) e.res = {{32{w[31]}}, w};
    return e;
  endfunction

  task automatic cycle(input logic v, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] rd,
                       input logic ordy, input logic fl, input logic rs);
    exp_t e;
    @(negedge clk);
    in_valid = v; in_op = op; in_a = a; in_b = b; in_rd = rd;
    out_ready = ordy; flush = fl; rst = rs;
    #1;
    if (!rs && !fl) begin
      if (prev_stall) begin
        check("stall_valid", {63'b0, out_valid}, 64'd1);
        check("stall_result", out_result, prev_res);
        check("stall_rd", {59'b0, out_rd}, {59'b0, prev_rd});
      end
      if (out_valid && out_ready) begin
        xfers++;
        last_res = out_result;
        last_err = out_err;
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", {63'b0, out_valid}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("result", out_result, e.res);
          check("rd", {59'b0, out_rd}, {59'b0, e.rd});
          check("err", {63'b0, out_err}, {63'b0, e.err});
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = out_result;
      prev_rd    = out_rd;
    end else begin
      prev_stall = 1'b0;
    end
    last_acc = v && in_ready;
    if (last_acc) exp_q.push_back(model(op, a, b, rd));
    if (rs || fl) exp_q.delete();
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 3'd0, 64'd0, 64'd0, 5'd0, ordy, 1'b0, 1'b0);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      idle(1'b1);
      n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int          x0;
    logic        rv, rr;
    logic [2:0]  rop;
    logic [63:0] ra, rb;

    // Reset state
    cycle(1'b0, 3'd0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 3'd1, 64'd5, 64'd1, 5'd9, 1'b0, 1'b0, 1'b1);
    check("rst_in_ready", {63'b0, in_ready}, 64'd0);
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_out_result", out_result, 64'd0);
    check("rst_out_rd", {59'b0, out_rd}, 64'd0);
    check("rst_out_err", {63'b0, out_err}, 64'd0);

    // SRL by 63 with latency check
    cycle(1'b1, 3'd1, 64'h8000_0000_0000_0000, 64'd63, 5'd1, 1'b1, 1'b0, 1'b0);
    check("srl_accept", {63'b0, last_acc}, 64'd1);
    idle(1'b1);
    check("lat_not_yet", {63'b0, out_valid}, 64'd0);
    idle(1'b1);
    check("lat_out_valid", {63'b0, out_valid}, 64'd1);
    drain(10);
    check("srl63", last_res, 64'h1);
    check("srl63_err", {63'b0, last_err}, 64'd0);

    cycle(1'b1, 3'd2, 64'hF000_0000_0000_0000, 64'h104, 5'd2, 1'b1, 1'b0, 1'b0);
    drain(10);
    check("sra4", last_res, 64'hFF00_0000_0000_0000);

    cycle(1'b1, 3'd2, 64'h8000_0000_0000_0001, 64'd63, 5'd3, 1'b1, 1'b0, 1'b0);
    drain(10);
    check("sra63_neg", last_res, 64'hFFFF_FFFF_FFFF_FFFF);

    cycle(1'b1, 3'd3, 64'h0000_0000_4000_0001, 64'd1, 5'd4, 1'b1, 1'b0, 1'b0);
    drain(10);
    check("sllw1", last_res, 64'hFFFF_FFFF_8000_0002);

    cycle(1'b1, 3'd4, 64'hFFFF_FFFF_8000_0000, 64'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    drain(10);
    check("srlw0", last_res, 64'hFFFF_FFFF_8000_0000);

    cycle(1'b1, 3'd0, 64'h1234_5678_9ABC_DEF0, 64'hFFC0, 5'd6, 1'b1, 1'b0, 1'b0);
    drain(10);
    check("sll0", last_res, 64'h1234_5678_9ABC_DEF0);

    cycle(1'b1, 3'd7, 64'h1234, 64'd2, 5'd7, 1'b1, 1'b0, 1'b0);
    drain(10);
    check("illegal_result", last_res, 64'd0);
    check("illegal_err", {63'b0, last_err}, 64'd1);

    // Back-to-back stream with writeback stalled
    x0 = xfers;
    cycle(1'b1, 3'd1, 64'hAAAA_0000_0000_0000, 64'd4, 5'd11, 1'b0, 1'b0, 1'b0);
    check("stream_rdy_a", {63'b0, in_ready}, 64'd1);
    cycle(1'b1, 3'd0, 64'h0000_0000_0000_00FF, 64'd8, 5'd12, 1'b0, 1'b0, 1'b0);
    check("stream_rdy_b", {63'b0, in_ready}, 64'd1);
    cycle(1'b1, 3'd5, 64'h0000_0000_8000_0000, 64'd3, 5'd13, 1'b0, 1'b0, 1'b0);
    check("stream_full", {63'b0, in_ready}, 64'd0);
    cycle(1'b1, 3'd5, 64'h0000_0000_8000_0000, 64'd3, 5'd13, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 3'd5, 64'h0000_0000_8000_0000, 64'd3, 5'd13, 1'b0, 1'b0, 1'b0);
    check("stream_still_full", {63'b0, in_ready}, 64'd0);
    cycle(1'b1, 3'd5, 64'h0000_0000_8000_0000, 64'd3, 5'd13, 1'b1, 1'b0, 1'b0);
    check("stream_c_accept", {63'b0, last_acc}, 64'd1);
    drain(10);
    check("stream_count", 64'(xfers - x0), 64'd3);

    // Flush with two ops in flight and a request presented
    cycle(1'b1, 3'd1, 64'd100, 64'd1, 5'd20, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 3'd1, 64'd200, 64'd1, 5'd21, 1'b0, 1'b0, 1'b0);
    x0 = xfers;
    cycle(1'b1, 3'd1, 64'd300, 64'd1, 5'd22, 1'b0, 1'b1, 1'b0);
    check("flush_in_ready", {63'b0, in_ready}, 64'd0);
    idle(1'b1);
    check("flush_out_valid", {63'b0, out_valid}, 64'd0);
    check("flush_busy", {63'b0, busy}, 64'd0);
    idle(1'b1);
    idle(1'b1);
    check("flush_no_output", 64'(xfers - x0), 64'd0);

    // Reset mid-stream
    cycle(1'b1, 3'd2, 64'hFFFF_0000_0000_0000, 64'd2, 5'd25, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 3'd2, 64'h0F00_0000_0000_0000, 64'd2, 5'd26, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 3'd2, 64'h0F00_0000_0000_0000, 64'd2, 5'd27, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    check("midrst_out_valid", {63'b0, out_valid}, 64'd0);
    check("midrst_out_result", out_result, 64'd0);
    check("midrst_out_rd", {59'b0, out_rd}, 64'd0);
    check("midrst_busy", {63'b0, busy}, 64'd0);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      rv  = ($urandom_range(0, 3) != 0);
      rr  = ($urandom_range(0, 3) != 0);
      rop = 3'($urandom_range(0, 7));
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      case ($urandom_range(0, 4))
        0: rb[5:0] = 6'd0;
        1: rb[5:0] = 6'd63;
        2: rb[5:0] = 6'd31;
        3: rb[5:0] = 6'd32;
        default: ;
      endcase
      cycle(rv, rop, ra, rb, 5'($urandom), rr, 1'b0, 1'b0);
    end
    drain(20);
    idle(1'b1);
    check("final_out_valid", {63'b0, out_valid}, 64'd0);
    check("final_busy", {63'b0, busy}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
